// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler that time-shares one combinational
// WIDTH x WIDTH unsigned multiplier among N_REQ requesters. One request is
// granted at a time, its operands are latched, and the product is returned
// with the winner's id on a valid/ready result port.
module mult_share_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  output logic [2*WIDTH-1:0]       res_prod,
  output logic [ID_W-1:0]          res_id,
  input  logic                     res_ready,
  output logic                     busy
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [ID_W-1:0]   id_q;
  logic              res_valid_q;
  logic [PW-1:0]     res_prod_q;
  logic [ID_W-1:0]   res_id_q;

  logic              found_c;
  logic [ID_W-1:0]   win_c;
  logic [ID_W-1:0]   idx_c;
  logic [WIDTH-1:0]  a_sel_c;
  logic [WIDTH-1:0]  b_sel_c;
  logic [N_REQ-1:0]  grant_c;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [PW-1:0]     prod_c;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx_c = ID_W'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_c == ID_W'(i)) begin
        a_sel_c = req_a[i*WIDTH +: WIDTH];
        b_sel_c = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant vector, pointer advance and the shared multiplier.
  always_comb begin
    grant_c  = N_REQ'(1) << win_c;
    rr_ptr_d = (win_c == ID_W'(N_REQ - 1)) ? '0 : win_c + ID_W'(1);
    prod_c   = PW'(a_q) * PW'(b_q);
  end

  assign req_ready = (state_q == IDLE && !rst && found_c) ? grant_c : '0;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

  // Scheduler FSM: grant in IDLE, multiply in CALC, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_prod_q  <= '0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_c) begin
            a_q      <= a_sel_c;
            b_q      <= b_sel_c;
            id_q     <= win_c;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          res_prod_q  <= prod_c;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched.
module tb_mult_share_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned ID_W  = 2;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   res_valid;
  logic [2*WIDTH-1:0]     res_prod;
  logic [ID_W-1:0]        res_id;
  logic                   res_ready;
  logic                   busy;

  int n_checks;
  int n_fail;

  mult_share_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_prod  (res_prod),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input int a, input int b);
    req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Single-requester transaction; requester drops valid and scrambles operands after acceptance.
  task automatic run_txn(input int id, input int a, input int b, input string tag);
    logic [31:0] onehot;
    onehot = 32'(1) << id;
    req_valid = '0;
    req_valid[id] = 1'b1;
    set_ops(id, a, b);
    #1;
    check_eq({tag, "_grant"}, 32'(req_ready), onehot);
    tick();
    req_valid = '0;
    req_a = '1;
    req_b = '1;
    #1;
    check_eq({tag, "_calc_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_calc_busy"}, 32'(busy), 32'd1);
    tick();
    check_eq({tag, "_valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, "_prod"}, 32'(res_prod), 32'(a * b));
    check_eq({tag, "_id"}, 32'(res_id), 32'(id));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    check_eq({tag, "_drop"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    tick();
    // Reset state, including no grant while rst is high.
    req_valid = 4'b1111;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_prod", 32'(res_prod), 32'd0);
    check_eq("rst_id", 32'(res_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // 1: req0 5*7 = 35
    run_txn(0, 5, 7, "t1");

    // 2: all four held valid from reset, res_ready held high
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, i + 2);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      int e;
      e = g % 4;
      #1;
      check_eq("t2_grant", 32'(req_ready), 32'(1) << e);
      tick();
      check_eq("t2_calc_ready", 32'(req_ready), 32'd0);
      tick();
      check_eq("t2_id", 32'(res_id), 32'(e));
      check_eq("t2_prod", 32'((e + 1) * (e + 2)), 32'(res_prod));
      tick();
    end
    req_valid = '0;
    res_ready = 1'b0;
    tick();

    // 3: rr_ptr is now 2; req2 7*7 with res_ready held low for 5 cycles, req0 waiting
    set_ops(2, 7, 7);
    set_ops(0, 1, 1);
    req_valid = 4'b0101;
    #1;
    check_eq("t3_grant", 32'(req_ready), 32'b0100);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("t3_hold_valid", 32'(res_valid), 32'd1);
      check_eq("t3_hold_prod", 32'(res_prod), 32'd49);
      check_eq("t3_hold_id", 32'(res_id), 32'd2);
      check_eq("t3_hold_ready", 32'(req_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    check_eq("t3_release", 32'(res_valid), 32'd0);
    check_eq("t3_wrap_grant", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick();

    // 4: exhaustive sweep on requester 3
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_txn(3, a, b, "t4");
      end
    end

    // 5: reset in CALC drops the transaction
    do_reset();
    tick();
    set_ops(1, 3, 6);
    req_valid = 4'b0010;
    #1;
    check_eq("t5_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("t5_valid", 32'(res_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_prod", 32'(res_prod), 32'd0);
    tick();
    tick();
    check_eq("t5_no_result", 32'(res_valid), 32'd0);
    req_valid = 4'b1010;
    #1;
    check_eq("t5_next_grant", 32'(req_ready), 32'b0010);
    req_valid = '0;
    tick();

    // 6: req1 drops valid in CALC, 4*5 = 20
    run_txn(1, 4, 5, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
